// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LAUNCH,
    ARB_WAIT_BUSY,
    ARB_WAIT_DONE
  } arb_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_picker
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  always_comb begin
    int idx;
    logic [ID_W-1:0] sel;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_id   = sel;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers,
// with a watchdog that drops a launch the transmitter never acknowledges.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_WIDTH   = 8,
  parameter  int BUSY_TIMEOUT = 4,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_par_en,
  input  logic [NUM_REQ-1:0]            req_par_typ,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_data_valid,
  output logic [DATA_WIDTH-1:0]         tx_p_data,
  output logic                          tx_par_en,
  output logic                          tx_par_typ,
  input  logic                          tx_busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          timeout_err
);

  // state         | meaning
  // ARB_IDLE      | offer req_ready to the round-robin winner
  // ARB_LAUNCH    | tx_data_valid pulse, watchdog loaded
  // ARB_WAIT_BUSY | wait for tx_busy to rise, watchdog counting down
  // ARB_WAIT_DONE | frame on the wire, wait for tx_busy to fall

  arb_state_t         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [7:0]         wdog;
  logic               ready_en;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               xfer;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // ready_en keeps req_ready low while reset is held and for the cycle it releases
  assign req_ready = (ready_en && state == ARB_IDLE && !tx_busy) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= ARB_IDLE;
      rr_ptr        <= '0;
      wdog          <= '0;
      ready_en      <= 1'b0;
      tx_data_valid <= 1'b0;
      tx_p_data     <= '0;
      tx_par_en     <= 1'b0;
      tx_par_typ    <= PAR_EVEN;
      grant_id      <= '0;
      timeout_err   <= 1'b0;
    end else begin
      ready_en      <= 1'b1;
      tx_data_valid <= 1'b0;
      timeout_err   <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (xfer) begin
            tx_p_data     <= req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
            tx_par_en     <= req_par_en[gnt_id];
            tx_par_typ    <= req_par_typ[gnt_id];
            grant_id      <= gnt_id;
            rr_ptr        <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
            tx_data_valid <= 1'b1;
            state         <= ARB_LAUNCH;
          end
        end
        ARB_LAUNCH: begin
          wdog  <= 8'(BUSY_TIMEOUT);
          state <= ARB_WAIT_BUSY;
        end
        ARB_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= ARB_WAIT_DONE;
          end else begin
            // terminal count: the byte is dropped, rr_ptr stays advanced
            wdog <= wdog - 8'd1;
            if (wdog == 8'd1) begin
              timeout_err <= 1'b1;
              state       <= ARB_IDLE;
            end
          end
        end
        ARB_WAIT_DONE: begin
          if (!tx_busy) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: frame-level timing model plus directed scenarios.
module tb_uart_tx_arbiter;

  localparam int BT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_par_en;
  logic [3:0]  req_par_typ;
  logic [3:0]  req_ready;
  logic        tx_data_valid;
  logic [7:0]  tx_p_data;
  logic        tx_par_en;
  logic        tx_par_typ;
  logic        tx_busy = 1'b0;
  logic [1:0]  grant_id;
  logic        timeout_err;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BUSY_TIMEOUT(BT)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_par_en    (req_par_en),
    .req_par_typ   (req_par_typ),
    .req_ready     (req_ready),
    .tx_data_valid (tx_data_valid),
    .tx_p_data     (tx_p_data),
    .tx_par_en     (tx_par_en),
    .tx_par_typ    (tx_par_typ),
    .tx_busy       (tx_busy),
    .grant_id      (grant_id),
    .timeout_err   (timeout_err)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // transmitter stand-in: busy for tx_len cycles starting one cycle after the launch
  int   tx_len = 12;
  int   tx_cnt = 0;
  logic s_tv, s_rst;
  always begin
    @(negedge CLK);
    s_tv  = tx_data_valid;
    s_rst = RST;
    @(posedge CLK);
    #1;
    if (s_rst) tx_cnt = 0;
    else if (s_tv && tx_len > 0) tx_cnt = tx_len;
    else if (tx_cnt > 0) tx_cnt--;
    tx_busy = (tx_cnt > 0);
  end

  function automatic logic [3:0] pick(input logic [3:0] v, input int p);
    logic [3:0] g;
    g = '0;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (g == 4'd0 && v[2'(j)]) g[2'(j)] = 1'b1;
    end
    return g;
  endfunction

  // model: a frame occupies the arbiter from its transfer until busy has risen and
  // fallen again, or until BT launch-relative cycles pass without busy
  int         cyc = 0;
  int         m_ptr, m_avail_from, m_launch, m_to_cyc, m_seen_cyc;
  bit         m_inflight, m_seen;
  logic [7:0] e_data;
  logic       e_pe, e_pt;
  logic [1:0] e_id;
  logic [3:0] e_ready;

  int gq[$];
  int last_launch_cyc = 0;
  int last_to_cyc     = 0;
  bit to_seen         = 0;

  always @(negedge CLK) begin
    int id;
    cyc++;
    if (RST) begin
      m_ptr        = 0;
      m_inflight   = 0;
      m_seen       = 0;
      m_launch     = -10;
      m_to_cyc     = -10;
      m_avail_from = cyc + 2;
      e_data = 8'h00; e_pe = 1'b0; e_pt = 1'b0; e_id = 2'd0;
      e_ready = 4'b0000;
    end else begin
      if (m_inflight) begin
        if (!m_seen && cyc > m_launch && cyc <= m_launch + BT && tx_busy) begin
          m_seen = 1; m_seen_cyc = cyc;
        end else if (m_seen && cyc > m_seen_cyc && !tx_busy) begin
          m_inflight = 0; m_avail_from = cyc + 1;
        end else if (!m_seen && cyc == m_launch + BT + 1) begin
          m_inflight = 0; m_avail_from = cyc; m_to_cyc = cyc;
        end
      end
      e_ready = (!m_inflight && cyc >= m_avail_from && !tx_busy) ? pick(req_valid, m_ptr) : 4'b0000;
    end
    chk("req_ready",     32'(req_ready),     32'(e_ready));
    chk("tx_data_valid", 32'(tx_data_valid), 32'(cyc == m_launch));
    chk("timeout_err",   32'(timeout_err),   32'(cyc == m_to_cyc));
    chk("tx_p_data",     32'(tx_p_data),     32'(e_data));
    chk("tx_par_en",     32'(tx_par_en),     32'(e_pe));
    chk("tx_par_typ",    32'(tx_par_typ),    32'(e_pt));
    chk("grant_id",      32'(grant_id),      32'(e_id));
    if (tx_data_valid) begin
      chk("launch_while_busy", 32'(tx_busy), 32'd0);
      gq.push_back(int'(grant_id));
      last_launch_cyc = cyc;
    end
    if (timeout_err) begin
      last_to_cyc = cyc;
      to_seen     = 1;
    end
    if (!RST && (e_ready & req_valid) != 4'b0000) begin
      id = 0;
      for (int k = 0; k < 4; k++) if (e_ready[k]) id = k;
      e_data     = req_data[id*8 +: 8];
      e_pe       = req_par_en[id];
      e_pt       = req_par_typ[id];
      e_id       = 2'(id);
      m_ptr      = (id + 1) % 4;
      m_launch   = cyc + 1;
      m_inflight = 1;
      m_seen     = 0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic pe, input logic pt);
    req_data[i*8 +: 8] = d;
    req_par_en[i]      = pe;
    req_par_typ[i]     = pt;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_grants(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (gq.size() < target && k < budget) begin
      tick();
      k++;
    end
    chk(nm, 32'(gq.size() >= target), 32'd1);
  endtask

  function automatic int grant_at(input int n);
    return (n < gq.size()) ? gq[n] : -1;
  endfunction

  initial begin
    int n0;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    RST = 1'b1; req_valid = '0; req_data = '0; req_par_en = '0; req_par_typ = '0;
    repeat (3) tick();
    chk("rst_ready",  32'(req_ready), 32'd0);
    chk("rst_hold",   32'({tx_p_data, tx_par_en, tx_par_typ, grant_id}), 32'd0);
    RST = 1'b0;
    tick();

    // single request
    set_req(0, 8'hA5, 1'b1, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    chk("t1_tv",    32'(tx_data_valid), 32'd1);
    chk("t1_data",  32'(tx_p_data),     32'hA5);
    chk("t1_paren", 32'(tx_par_en),     32'd1);
    chk("t1_gid",   32'(grant_id),      32'd0);
    req_valid = 4'b0000;
    repeat (20) tick();

    // all four held valid, grants rotate
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h30 + i), i[0], i[1]);
    req_valid = 4'b1111;
    n0 = gq.size();
    wait_grants(n0 + 5, 200, "t2_grants_budget");
    req_valid = 4'b0000;
    for (int k = 0; k < 5; k++) chk("t2_order", 32'(grant_at(n0 + k)), 32'(exp_order[k]));
    repeat (20) tick();

    // transmitter never goes busy
    do_reset();
    tx_len  = 0;
    to_seen = 0;
    set_req(0, 8'h5A, 1'b0, 1'b1);
    req_valid = 4'b0001;
    n0 = gq.size();
    wait_grants(n0 + 1, 20, "t3_launch_budget");
    req_valid = 4'b0000;
    for (int k = 0; k < 20 && !to_seen; k++) tick();
    chk("t3_timeout_seen",   32'(to_seen), 32'd1);
    chk("t3_timeout_offset", 32'(last_to_cyc - last_launch_cyc), 32'd5);
    tx_len    = 12;
    req_valid = 4'b1111;
    n0 = gq.size();
    wait_grants(n0 + 1, 20, "t3_next_budget");
    chk("t3_next_grant", 32'(grant_at(n0)), 32'd1);

    // reset in the middle of the busy period
    req_valid = 4'b0000;
    repeat (4) tick();
    RST = 1'b1;
    #1;
    chk("t4_rst_ready", 32'(req_ready), 32'd0);
    chk("t4_rst_pulse", 32'({tx_data_valid, timeout_err}), 32'd0);
    chk("t4_rst_hold",  32'({tx_p_data, tx_par_en, tx_par_typ, grant_id}), 32'd0);
    tick();
    RST = 1'b0;
    set_req(2, 8'hC3, 1'b1, 1'b1);
    req_valid = 4'b0100;
    n0 = gq.size();
    wait_grants(n0 + 1, 20, "t4_launch_budget");
    chk("t4_grant", 32'(grant_at(n0)), 32'd2);
    chk("t4_data",  32'(tx_p_data),    32'hC3);
    req_valid = 4'b0000;
    repeat (20) tick();

    // requester 1 withdraws while 3 owns the transmitter
    set_req(0, 8'h11, 1'b0, 1'b0);
    set_req(1, 8'h22, 1'b1, 1'b0);
    set_req(3, 8'h33, 1'b1, 1'b1);
    req_valid = 4'b1011;
    n0 = gq.size();
    wait_grants(n0 + 1, 20, "t5_first_budget");
    chk("t5_first", 32'(grant_at(n0)), 32'd3);
    req_valid = 4'b0001;
    wait_grants(n0 + 2, 40, "t5_second_budget");
    chk("t5_second", 32'(grant_at(n0 + 1)), 32'd0);
    chk("t5_data",   32'(tx_p_data),        32'h11);
    req_valid = 4'b0000;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
